// File: rtl/fetch_sequencer.sv
// Fetch-side sequencer: drives ProgramCounter load, instruction-memory
// requests, IF/ID valid/flush, and counts accepted fetches.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc_out,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   input  logic             imem_ready,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   output logic [31:0]      next_pc,
   output logic             PCWrite,
   output logic             if_valid,
   output logic             if_flush,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
   logic [31:0]       redirect_tgt;

   // Redirect targets are always word aligned.
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign imem_addr    = pc_out;
   assign fetch_count  = fetch_count_q;

   // State and accepted-fetch counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_BOOT;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // Next-state and Mealy outputs; reset overrides outputs asynchronously.
   always_comb begin
      state_d       = state_q;
      fetch_count_d = fetch_count_q;
      imem_req      = 1'b0;
      PCWrite       = 1'b0;
      next_pc       = pc_out;
      if_valid      = 1'b0;
      if_flush      = 1'b0;

      case (state_q)
         ST_BOOT: begin
            PCWrite = 1'b1;
            next_pc = RESET_VECTOR;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (redirect_valid) begin
               // In-flight request is abandoned; its data is dropped in DRAIN.
               PCWrite  = 1'b1;
               next_pc  = redirect_tgt;
               if_flush = 1'b1;
               state_d  = ST_DRAIN;
            end else if (imem_ready && !stall) begin
               PCWrite       = 1'b1;
               next_pc       = pc_out + 32'd4;
               if_valid      = 1'b1;
               fetch_count_d = fetch_count_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (redirect_valid) begin
               PCWrite  = 1'b1;
               next_pc  = redirect_tgt;
               if_flush = 1'b1;
            end else begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      if (!reset) begin
         imem_req = 1'b0;
         PCWrite  = 1'b0;
         next_pc  = RESET_VECTOR;
         if_valid = 1'b0;
         if_flush = 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural reference model
// and a simple ProgramCounter model closing the loop on next_pc/PCWrite.
module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0100;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic [31:0] npc;
      logic        pcw;
      logic        iv;
      logic        fl;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_out = 32'h0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] next_pc;
   logic        PCWrite;
   logic        if_valid;
   logic        if_flush;
   logic [15:0] fetch_count;

   exp_t        exp_q[$];
   logic [31:0] fetch_q[$];
   int          n_chk = 0;
   int          n_pass = 0;

   // Reference model state: booting / bubble after a redirect / fetch count.
   bit          m_boot = 1'b1;
   bit          m_bubble = 1'b0;
   logic [15:0] m_cnt = 16'h0;

   fetch_sequencer #(.RESET_VECTOR(RV), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .pc_out(pc_out), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
      .next_pc(next_pc), .PCWrite(PCWrite), .if_valid(if_valid),
      .if_flush(if_flush), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // ProgramCounter stand-in.
   always @(posedge clk) if (PCWrite === 1'b1) pc_out <= next_pc;

   // One cycle of stimulus; expected outputs derived from the rules and queued.
   task automatic step(input bit rst, input bit st, input bit rdy,
                       input bit rv, input logic [31:0] rpc);
      exp_t e;
      logic [31:0] tgt;
      @(posedge clk);
      #1;
      reset = rst; stall = st; imem_ready = rdy;
      redirect_valid = rv; redirect_pc = rpc;
      tgt = rpc & ~32'h3;
      e = '{req: 1'b0, addr: pc_out, npc: pc_out, pcw: 1'b0,
            iv: 1'b0, fl: 1'b0, cnt: m_cnt};
      if (!rst) begin
         e.npc = RV; e.cnt = 16'h0;
         m_boot = 1'b1; m_bubble = 1'b0; m_cnt = 16'h0;
      end else if (m_boot) begin
         e.pcw = 1'b1; e.npc = RV;
         m_boot = 1'b0;
      end else if (m_bubble) begin
         if (rv) begin
            e.pcw = 1'b1; e.npc = tgt; e.fl = 1'b1;
         end else begin
            m_bubble = 1'b0;
         end
      end else begin
         e.req = 1'b1;
         if (rv) begin
            e.pcw = 1'b1; e.npc = tgt; e.fl = 1'b1;
            m_bubble = 1'b1;
         end else if (rdy && !st) begin
            e.pcw = 1'b1; e.npc = pc_out + 32'd4; e.iv = 1'b1;
            fetch_q.push_back(pc_out);
            m_cnt = m_cnt + 16'd1;
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare every presented cycle, and every IF/ID capture address.
   always @(negedge clk) begin
      exp_t e, a;
      logic [31:0] fa;
      a = '{req: imem_req, addr: imem_addr, npc: next_pc, pcw: PCWrite,
            iv: if_valid, fl: if_flush, cnt: fetch_count};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (a !== e)
            $display("FAIL outputs t=%0t act req=%b addr=%h npc=%h pcw=%b iv=%b fl=%b cnt=%h exp req=%b addr=%h npc=%h pcw=%b iv=%b fl=%b cnt=%h",
                     $time, a.req, a.addr, a.npc, a.pcw, a.iv, a.fl, a.cnt,
                     e.req, e.addr, e.npc, e.pcw, e.iv, e.fl, e.cnt);
         else
            n_pass++;
      end
      if (if_valid === 1'b1) begin
         n_chk++;
         if (fetch_q.size() == 0) begin
            $display("FAIL fetch_addr t=%0t act unexpected if_valid at %h exp none", $time, imem_addr);
         end else begin
            fa = fetch_q.pop_front();
            if (imem_addr !== fa)
               $display("FAIL fetch_addr t=%0t act %h exp %h", $time, imem_addr, fa);
            else
               n_pass++;
         end
      end
   end

   initial begin
      // Reset held two cycles, then boot and stream four fetches.
      step(0,0,0,0,0); step(0,0,0,0,0);
      step(1,0,0,0,0);
      for (int i = 0; i < 4; i++) step(1,0,1,0,0);
      step(1,0,0,0,0);
      // Memory wait, then stall with ready, then accepted fetch at 0x200.
      step(1,0,0,1,32'h200); step(1,0,0,0,0);
      step(1,0,0,0,0); step(1,0,0,0,0);
      step(1,1,1,0,0); step(1,0,1,0,0);
      // Redirect at 0x300 colliding with ready; stale ready in DRAIN dropped.
      step(1,0,0,1,32'h300); step(1,0,0,0,0);
      step(1,0,1,1,32'h47); step(1,0,1,0,0); step(1,0,0,0,0);
      // PC wrap from 0xFFFF_FFFC.
      step(1,0,0,1,32'hFFFF_FFFF); step(1,0,0,0,0);
      step(1,0,1,0,0); step(1,0,1,0,0);
      // Redirect while in DRAIN stays in DRAIN.
      step(1,0,0,1,32'h500); step(1,0,1,1,32'h80);
      step(1,0,1,0,0); step(1,0,1,0,0);
      // Redirect with stall.
      step(1,1,1,1,32'h600); step(1,0,0,0,0); step(1,0,1,0,0);
      // Asynchronous reset in DRAIN with a pending target, then reboot.
      step(1,0,0,1,32'h700); step(0,0,1,1,32'h900);
      step(0,0,1,0,0); step(1,0,0,1,32'h44); step(1,0,1,0,0);
      // Long stream so fetch_count passes 16'hFFFF and wraps.
      for (int i = 0; i < 65540; i++) step(1,0,1,0,0);
      // Randomised traffic including occasional resets.
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0,149) != 0),
              ($urandom_range(0,3) == 0),
              ($urandom_range(0,2) != 0),
              ($urandom_range(0,9) == 0),
              $urandom);
      @(negedge clk);
      #1;
      n_chk++;
      if (exp_q.size() != 0 || fetch_q.size() != 0)
         $display("FAIL drain_queues act exp=%0d fetch=%0d exp 0/0", exp_q.size(), fetch_q.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-side controller that produces the `next_pc` and `PCWrite` inputs of `ProgramCounter` and consumes its `pc_out`. It runs instruction-memory requests with a ready handshake, applies load-use stalls and branch/jump redirects, flushes IF/ID on redirect, and marks valid fetches into IF/ID. It sits in the IF stage between `ProgramCounter`, instruction memory, the hazard unit and the EX-stage branch resolver.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first PC loaded after reset.
- `CNT_W`, default 16: width of the fetched-instruction counter.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `pc_out`  in  32  current PC from `ProgramCounter`
- `stall`  in  1  hazard-unit stall request
- `redirect_valid`  in  1  EX-stage taken branch/jump
- `redirect_pc`  in  32  redirect target
- `imem_ready`  in  1  instruction data for `imem_addr` valid this cycle
- `imem_req`  out  1  instruction-memory request
- `imem_addr`  out  32  fetch address
- `next_pc`  out  32  PC to load
- `PCWrite`  out  1  PC load enable
- `if_valid`  out  1  IF/ID load enable with valid instruction
- `if_flush`  out  1  IF/ID flush (insert bubble)
- `fetch_count`  out  CNT_W  registered count of accepted fetches

## Operation
- States: BOOT, FETCH, DRAIN. Only state and `fetch_count` are registered. All other outputs are combinational from state and inputs (Mealy).
- `imem_addr` = `pc_out` in every state.
- Default outputs: `imem_req`=0, `PCWrite`=0, `next_pc`=`pc_out`, `if_valid`=0, `if_flush`=0.
- Effective redirect target: {`redirect_pc`[31:2], 2'b00}. Low bits are always cleared.
- BOOT:
  - `PCWrite`=1, `next_pc`=RESET_VECTOR.
  - `redirect_valid` and `stall` are ignored.
  - Next state is FETCH.
- FETCH, with `imem_req`=1. Conditions are checked in this priority order:
  1. `redirect_valid`: `PCWrite`=1, `next_pc`=target, `if_flush`=1, `if_valid`=0. The outstanding request is abandoned. Next state DRAIN.
  2. `imem_ready` and not `stall`: `PCWrite`=1, `next_pc`=`pc_out`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), `if_valid`=1, `fetch_count` increments. Stay in FETCH.
  3. Otherwise (`imem_ready` with `stall`, or not `imem_ready`): hold. `PCWrite`=0, `if_valid`=0. The same address is re-requested next cycle.
- DRAIN, with `imem_req`=0:
  - `imem_ready` is ignored (stale data dropped).
  - If `redirect_valid`: `PCWrite`=1, `next_pc`=target, `if_flush`=1, and stay in DRAIN.
  - Otherwise go to FETCH.
- `fetch_count` wraps modulo 2^CNT_W. It counts only accepted fetches (FETCH case 2).

## Timing
- While `reset`=0, immediately and asynchronously: state=BOOT, `fetch_count`=0, `imem_req`=0, `PCWrite`=0, `if_valid`=0, `if_flush`=0, `next_pc`=RESET_VECTOR, `imem_addr`=`pc_out`.
- First edge after `reset` rises: BOOT issues `PCWrite`. `pc_out` equals RESET_VECTOR one edge later, and the FETCH request starts that cycle.
- Fetch latency:
  - One cycle per instruction when `imem_ready` is held high. The PC advances at the same edge that IF/ID captures the instruction.
  - N wait cycles of `imem_ready`=0 add N cycles.
- Redirect:
  - Target lands in the PC at the edge ending the redirect cycle.
  - One DRAIN bubble cycle follows.
  - The first fetch from the target is requested 2 cycles after the redirect cycle began.
- Simultaneous events in FETCH:
  - Redirect + `imem_ready`: redirect wins, no `if_valid`.
  - Redirect + `stall`: redirect wins.
  - `stall` + `imem_ready`: no advance, no count.
- Reset asserted mid-operation (any state, including DRAIN with a pending target): everything is discarded and the block restarts in BOOT.

## Test plan
- **Reset/boot.** RESET_VECTOR=32'h100. Hold `reset`=0 for 2 cycles, then release.
  - During reset: all outputs at reset values.
  - First cycle after release: `PCWrite`=1, `next_pc`=32'h100.
  - Next cycle: `imem_req`=1, `imem_addr`=32'h100.
- **Streaming.** `imem_ready`=1 for 4 cycles from PC 32'h100.
  - `if_valid` high in each cycle.
  - `next_pc` sequence 32'h104, 32'h108, 32'h10C, 32'h110.
  - `fetch_count`=4.
- **Memory wait and stall.** PC 32'h200, `imem_ready`=0 for 2 cycles, then 1 with `stall`=1, then 1 with `stall`=0.
  - `PCWrite`=0 and `if_valid`=0 for the first 3 cycles.
  - 4th cycle: `next_pc`=32'h204, `if_valid`=1.
- **Redirect.** In FETCH at 32'h300, `redirect_valid`=1, `redirect_pc`=32'h47, `imem_ready`=1.
  - Same cycle: `if_flush`=1, `if_valid`=0, `next_pc`=32'h44.
  - Next cycle: DRAIN with `imem_req`=0.
  - Cycle after that: `imem_addr`=32'h44.
- **Wrap and redirect in DRAIN.**
  - `pc_out`=32'hFFFF_FFFC with `imem_ready`=1 gives `next_pc`=0.
  - `fetch_count` at 16'hFFFF wraps to 0.
  - Redirect to 32'h80 while in DRAIN gives `PCWrite`=1, `next_pc`=32'h80; state stays DRAIN.
- **Mid-operation reset.** Drive `reset`=0 in DRAIN. Outputs drop to reset values without waiting for a clock edge, `fetch_count`=0, and the block restarts the BOOT sequence.
